// File: rtl/microcode_exec.sv
// Microcode sequencer/executor: one uop per clock from a static uop array into a 16x32 register file.
// Optional simulation trace: define MICROCODE_EXEC_TRACE_EN.
module microcode_exec #(
  parameter int NUM_UOPS = 129,
  parameter int UOP_W    = 32,
  parameter int NUM_REGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [UOP_W-1:0] uops [NUM_UOPS]
);

  typedef enum logic { ST_RUN = 1'b0, ST_HALT = 1'b1 } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB  = 4'h3,
    OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_SHL  = 4'h7,
    OP_SHR  = 4'h8, OP_ADDI = 4'h9, OP_JMP = 4'hA, OP_BEQ = 4'hB,
    OP_BNE  = 4'hC, OP_CALL = 4'hD, OP_RET = 4'hE, OP_HALT = 4'hF
  } op_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
  } uop_t;

  localparam logic [8:0] UPC_LIM = 9'(NUM_UOPS);
  localparam logic [3:0] LINK_REG = 4'd15;

  // Architectural state keeps the hierarchical names used by checkers.
  state_e      state_q, state_d;
  logic [7:0]  upc, upc_d;
  logic [31:0] regs [0:NUM_REGS-1];
  logic [31:0] regs_d [0:NUM_REGS-1];
  logic        halted;
  logic        err, err_d;
  logic [31:0] retired, retired_d;

  uop_t        cur;
  logic [31:0] rs1_v, rs2_v;
  logic [8:0]  pc_inc, tgt, nxt;
  logic        wr_en;
  logic [31:0] wr_val;

  assign halted = (state_q == ST_HALT);

  always_comb begin
    cur = uop_t'(uops[upc][31:0]);
  end

  // r0 is hardwired to zero on the read side; writes to it are dropped below.
  always_comb begin
    rs1_v = (cur.rs1 == 4'd0) ? 32'd0 : regs[cur.rs1];
    rs2_v = (cur.rs2 == 4'd0) ? 32'd0 : regs[cur.rs2];
  end

  assign pc_inc = {1'b0, upc} + 9'd1;
  assign tgt    = {1'b0, cur.imm[7:0]};

  always_comb begin
    wr_en  = 1'b0;
    wr_val = 32'd0;
    nxt    = pc_inc;
    case (op_e'(cur.op))
      OP_LDI:  begin wr_en = 1'b1; wr_val = {16'd0, cur.imm}; end
      OP_ADD:  begin wr_en = 1'b1; wr_val = rs1_v + rs2_v; end
      OP_SUB:  begin wr_en = 1'b1; wr_val = rs1_v - rs2_v; end
      OP_AND:  begin wr_en = 1'b1; wr_val = rs1_v & rs2_v; end
      OP_OR:   begin wr_en = 1'b1; wr_val = rs1_v | rs2_v; end
      OP_XOR:  begin wr_en = 1'b1; wr_val = rs1_v ^ rs2_v; end
      OP_SHL:  begin wr_en = 1'b1; wr_val = rs1_v << rs2_v[4:0]; end
      OP_SHR:  begin wr_en = 1'b1; wr_val = rs1_v >> rs2_v[4:0]; end
      OP_ADDI: begin wr_en = 1'b1; wr_val = rs1_v + {{16{cur.imm[15]}}, cur.imm}; end
      OP_JMP:  nxt = tgt;
      OP_BEQ:  if (rs1_v == rs2_v) nxt = tgt;
      OP_BNE:  if (rs1_v != rs2_v) nxt = tgt;
      OP_CALL: begin wr_en = 1'b1; wr_val = {23'd0, pc_inc}; nxt = tgt; end
      OP_RET:  nxt = {1'b0, regs[LINK_REG][7:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    upc_d     = upc;
    err_d     = err;
    retired_d = retired;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs[i];
    case (state_q)
      ST_RUN: begin
        retired_d = retired + 32'd1;
        if (cur.op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (nxt >= UPC_LIM) begin
          // Out-of-range control flow stops the run; upc stays on the offender.
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          upc_d = nxt[7:0];
        end
        if (wr_en) begin
          if (cur.op == OP_CALL)      regs_d[LINK_REG] = wr_val;
          else if (cur.rd != 4'd0)    regs_d[cur.rd]   = wr_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      upc     <= 8'd0;
      err     <= 1'b0;
      retired <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      upc     <= upc_d;
      err     <= err_d;
      retired <= retired_d;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_d[i];
    end
  end

`ifdef MICROCODE_EXEC_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && !halted) begin
      $display("%0t upc=%0d uop=%h", $time, upc, uops[upc]);
      if (err_d)                  $display("%0t err: next upc out of range", $time);
      else if (state_d == ST_HALT) $display("%0t halted at upc=%0d", $time, upc);
    end
  end
`else
  // Trace disabled: silent build.
`endif

endmodule

// File: tb/tb_microcode_exec.sv
// Directed bench for microcode_exec: table of programs plus hand sequences for boundaries and reset.
module tb_microcode_exec;
  localparam int NU = 129;
  localparam logic [31:0] H = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] uops [NU];

  int nvec = 0;
  int nbad = 0;

  microcode_exec #(.NUM_UOPS(NU), .UOP_W(32), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .uops(uops)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              id;
    logic [0:7][31:0] prog;
    logic [31:0]     fill;
    int              cycles;
    int              exp_upc;   // -1: not checked
    logic            exp_halt;
    logic            exp_err;
    logic [31:0]     exp_ret;
    int              ra;
    logic [31:0]     va;
    int              rb;
    logic [31:0]     vb;
  } vec_t;

  vec_t vt [12];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [0:7][31:0] p, input logic [31:0] fill);
    for (int i = 0; i < NU; i++) uops[i] = (i < 8) ? p[i] : fill;
  endtask

  task automatic setv(input int k, input logic [0:7][31:0] p, input logic [31:0] fill,
                      input int cyc, input int eu, input logic eh, input logic ee,
                      input logic [31:0] er, input int ra, input logic [31:0] va,
                      input int rb, input logic [31:0] vb);
    vt[k].id = k; vt[k].prog = p; vt[k].fill = fill; vt[k].cycles = cyc;
    vt[k].exp_upc = eu; vt[k].exp_halt = eh; vt[k].exp_err = ee; vt[k].exp_ret = er;
    vt[k].ra = ra; vt[k].va = va; vt[k].rb = rb; vt[k].vb = vb;
  endtask

  logic [0:7][31:0] loop_prog;

  initial begin
    loop_prog = {enc(1,1,0,0,0), enc(1,2,0,0,4), enc(9,1,1,0,1), enc(4'hC,0,1,2,2), H, H, H, H};

    setv(0, {enc(1,1,0,0,5), enc(1,2,0,0,3), enc(2,3,1,2,0), enc(3,4,1,2,0), H, H, H, H},
         H, 5, 4, 1, 0, 5, 3, 32'd8, 4, 32'd2);
    setv(1, loop_prog, H, 11, 4, 1, 0, 11, 1, 32'd4, 2, 32'd4);
    setv(2, {enc(4'hD,0,0,0,5), H, H, H, H, enc(1,6,0,0,16'hBEEF), enc(4'hE,0,0,0,0), H},
         H, 4, 1, 1, 0, 4, 6, 32'hBEEF, 15, 32'd1);
    setv(3, {enc(4'hA,0,0,0,200), H, H, H, H, H, H, H}, H, 1, -1, 1, 1, 1, 1, 32'd0, 15, 32'd0);
    setv(4, {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
         32'd0, 129, -1, 1, 1, 129, 1, 32'd0, 15, 32'd0);
    setv(5, {enc(1,1,0,0,1), enc(1,0,0,0,7), enc(3,5,0,1,0), H, H, H, H, H},
         H, 4, 3, 1, 0, 4, 0, 32'd0, 5, 32'hFFFF_FFFF);
    setv(6, {enc(1,1,0,0,16'h8001), enc(1,2,0,0,16'h0024), enc(7,3,1,2,0), enc(8,4,1,2,0), H, H, H, H},
         H, 5, 4, 1, 0, 5, 3, 32'h0008_0010, 4, 32'h0000_0800);
    setv(7, {enc(1,1,0,0,16'hF0F0), enc(1,2,0,0,16'h0FF0), enc(4,3,1,2,0), enc(5,4,1,2,0),
             enc(6,5,1,2,0), H, H, H},
         H, 6, 5, 1, 0, 6, 3, 32'h0000_00F0, 5, 32'h0000_FF00);
    setv(8, {enc(1,1,0,0,5), enc(9,2,1,0,16'hFFFA), enc(9,3,1,0,16'h7FFF), H, H, H, H, H},
         H, 4, 3, 1, 0, 4, 2, 32'hFFFF_FFFF, 3, 32'h0000_8004);
    setv(9, {enc(1,1,0,0,3), enc(1,2,0,0,3), enc(4'hB,0,1,2,4), enc(1,7,0,0,1), H, H, H, H},
         H, 4, 4, 1, 0, 4, 7, 32'd0, 1, 32'd3);
    setv(10, {enc(1,15,0,0,200), enc(4'hE,0,0,0,0), H, H, H, H, H, H},
         H, 2, -1, 1, 1, 2, 15, 32'd200, 1, 32'd0);
    setv(11, {enc(4'hA,0,0,0,128), H, H, H, H, H, H, H}, H, 2, 128, 1, 0, 2, 1, 32'd0, 15, 32'd0);

    // Reset state
    load(loop_prog, H);
    do_reset();
    chk("rst_upc", -1, 32'(dut.upc), 32'd0);
    chk("rst_halted", -1, 32'(dut.halted), 32'd0);
    chk("rst_err", -1, 32'(dut.err), 32'd0);
    chk("rst_retired", -1, dut.retired, 32'd0);

    // First uop executes on the first posedge with reset high
    run(1);
    chk("lat_retired", -1, dut.retired, 32'd1);
    chk("lat_upc", -1, 32'(dut.upc), 32'd1);

    for (int k = 0; k < 12; k++) begin
      load(vt[k].prog, vt[k].fill);
      do_reset();
      run(vt[k].cycles + 3);
      if (vt[k].exp_upc >= 0) chk("upc", k, 32'(dut.upc), 32'(vt[k].exp_upc));
      chk("halted", k, 32'(dut.halted), 32'(vt[k].exp_halt));
      chk("err", k, 32'(dut.err), 32'(vt[k].exp_err));
      chk("retired", k, dut.retired, vt[k].exp_ret);
      chk("reg_a", k, dut.regs[vt[k].ra], vt[k].va);
      chk("reg_b", k, dut.regs[vt[k].rb], vt[k].vb);
    end

    // NOP run: still running at upc 128, error on the 129th retire
    load({32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}, 32'd0);
    do_reset();
    run(128);
    chk("nop128_err", 100, 32'(dut.err), 32'd0);
    chk("nop128_halted", 100, 32'(dut.halted), 32'd0);
    chk("nop128_upc", 100, 32'(dut.upc), 32'd128);
    run(1);
    chk("nop129_err", 100, 32'(dut.err), 32'd1);
    chk("nop129_retired", 100, dut.retired, 32'd129);

    // Reset mid-run then rerun to completion
    load(loop_prog, H);
    do_reset();
    run(5);
    chk("mid_retired", 101, dut.retired, 32'd5);
    chk("mid_r1", 101, dut.regs[1], 32'd2);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_upc", 101, 32'(dut.upc), 32'd0);
    chk("midrst_retired", 101, dut.retired, 32'd0);
    chk("midrst_r1", 101, dut.regs[1], 32'd0);
    chk("midrst_r2", 101, dut.regs[2], 32'd0);
    reset = 1'b1;
    run(11);
    chk("rerun_r1", 101, dut.regs[1], 32'd4);
    chk("rerun_retired", 101, dut.retired, 32'd11);
    chk("rerun_halted", 101, 32'(dut.halted), 32'd1);

    // Reset while halted clears the stop state
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hltrst_halted", 102, 32'(dut.halted), 32'd0);
    chk("hltrst_upc", 102, 32'(dut.upc), 32'd0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
